// File: rtl/hdlc_rx_pkg.sv
// Shared types and constants for the HDLC receive framing controller.
package hdlc_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_OPEN = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CLS_IDLE  = 3'd0,
    CLS_PUSH  = 3'd1,
    CLS_DROP  = 3'd2,
    CLS_PEND  = 3'd3,
    CLS_FLAG  = 3'd4,
    CLS_ABORT = 3'd5
  } bit_class_e;

  localparam logic [7:0] FLAG       = 8'h7E;
  localparam int         STUFF_ONES = 5;
  localparam int         DELAY_BITS = 6;

  function automatic int count_ones(input logic [7:0] pat);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(pat[i]);
    return n;
  endfunction

endpackage

// File: rtl/hdlc_destuff.sv
// Run-of-ones counter that classifies each raw bit as data, stuffing, flag or abort.
module hdlc_destuff
  import hdlc_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_vld,
  input  logic       clr,
  output bit_class_e o_class,
  output logic       o_bit
);

  localparam logic [2:0] OC_STUFF = 3'(STUFF_ONES);
  localparam logic [2:0] OC_PEND  = 3'(count_ones(FLAG));
  localparam logic [2:0] OC_ABORT = 3'd7;

  logic [2:0] r_oc;
  logic [2:0] w_oc_nxt;

  // Class is decoded from the registered run count so the top can act in the same cycle.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    o_class  = CLS_IDLE;
    o_bit    = bit_in;
    w_oc_nxt = r_oc;
    if (bit_vld) begin
      if (bit_in) begin
        if (r_oc < OC_STUFF) begin
          o_class  = CLS_PUSH;
          w_oc_nxt = r_oc + 3'd1;
        end else if (r_oc == OC_STUFF) begin
          o_class  = CLS_PEND;
          w_oc_nxt = OC_PEND;
        end else begin
          o_class  = CLS_ABORT;
          w_oc_nxt = OC_ABORT;
        end
      end else begin
        w_oc_nxt = '0;
        if (r_oc < OC_STUFF)       o_class = CLS_PUSH;
        else if (r_oc == OC_STUFF) o_class = CLS_DROP;
        else if (r_oc == OC_PEND)  o_class = CLS_FLAG;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (rst || clr) r_oc <= '0;
    else            r_oc <= w_oc_nxt;
  end

endmodule

// File: rtl/hdlc_rx_ctrl.sv
// HDLC receive framing: flag hunt, destuffed LSB-first byte assembly, frame report with host ack.
module hdlc_rx_ctrl
  import hdlc_rx_pkg::*;
#(
  parameter int MAX_BYTES = 255,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             ack,
  output logic [7:0]       byte_out,
  output logic             byte_vld,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [LEN_W-1:0] frame_len,
  output logic             synced
);

  localparam logic [2:0]       DL_FULL = 3'(DELAY_BITS);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);

  state_e                r_state,    w_state;
  logic [DELAY_BITS-1:0] r_dl,       w_dl;
  logic [2:0]            r_dl_cnt,   w_dl_cnt;
  logic [7:0]            r_asm,      w_asm;
  logic [2:0]            r_asm_cnt,  w_asm_cnt;
  logic [LEN_W-1:0]      r_cnt,      w_cnt;
  logic [7:0]            r_byte_out, w_byte_out;
  logic                  r_byte_vld, w_byte_vld;
  logic                  r_done,     w_done;
  logic                  r_ok,       w_ok;
  logic [LEN_W-1:0]      r_len,      w_len;
  logic                  r_synced;

  logic       w_ack;
  logic       w_bit_vld;
  logic       w_bit;
  bit_class_e w_class;
  logic [7:0] w_asm_shift;

  // A pending report freezes the bit stream, including the ones counter.
  assign w_ack       = ack && (r_state == ST_DONE);
  assign w_bit_vld   = bit_vld && (r_state != ST_DONE);
  assign w_asm_shift = {r_dl[0], r_asm[7:1]};

  hdlc_destuff u_destuff (
    .clk     (clk),
    .rst     (rst),
    .bit_in  (bit_in),
    .bit_vld (w_bit_vld),
    .clr     (w_ack),
    .o_class (w_class),
    .o_bit   (w_bit)
  );

  always_comb begin
    w_state    = r_state;
    w_dl       = r_dl;
    w_dl_cnt   = r_dl_cnt;
    w_asm      = r_asm;
    w_asm_cnt  = r_asm_cnt;
    w_cnt      = r_cnt;
    w_byte_out = r_byte_out;
    w_byte_vld = 1'b0;
    w_done     = r_done;
    w_ok       = r_ok;
    w_len      = r_len;

    case (r_state)
      ST_HUNT: begin
        if (w_class == CLS_FLAG) begin
          w_state   = ST_OPEN;
          w_dl      = '0;
          w_dl_cnt  = '0;
          w_asm     = '0;
          w_asm_cnt = '0;
          w_cnt     = '0;
        end
      end

      ST_OPEN, ST_DATA: begin
        case (w_class)
          CLS_PUSH: begin
            w_state = ST_DATA;
            w_dl    = {w_bit, r_dl[DELAY_BITS-1:1]};
            if (r_dl_cnt != DL_FULL) begin
              w_dl_cnt = r_dl_cnt + 3'd1;
            end else begin
              // The delay line holds back the 0+five 1s that a closing flag pushes.
              w_asm     = w_asm_shift;
              w_asm_cnt = r_asm_cnt + 3'd1;
              if (r_asm_cnt == 3'd7) begin
                if (r_cnt == LEN_MAX) begin
                  w_state = ST_DONE;
                  w_done  = 1'b1;
                  w_ok    = 1'b0;
                  w_len   = r_cnt;
                end else begin
                  w_byte_out = w_asm_shift;
                  w_byte_vld = 1'b1;
                  w_cnt      = r_cnt + LEN_W'(1);
                end
              end
            end
          end

          CLS_FLAG: begin
            w_dl      = '0;
            w_dl_cnt  = '0;
            w_asm     = '0;
            w_asm_cnt = '0;
            if (r_state == ST_OPEN || (r_cnt == '0 && r_asm_cnt == '0)) begin
              w_state = ST_OPEN;
            end else begin
              w_state = ST_DONE;
              w_done  = 1'b1;
              w_ok    = (r_dl_cnt == DL_FULL) && (r_asm_cnt == '0);
              w_len   = r_cnt;
            end
          end

          CLS_ABORT: begin
            if (r_state == ST_OPEN) begin
              w_state = ST_HUNT;
            end else begin
              w_state = ST_DONE;
              w_done  = 1'b1;
              w_ok    = 1'b0;
              w_len   = r_cnt;
            end
          end

          default: ;
        endcase
      end

      ST_DONE: begin
        if (w_ack) begin
          w_state = ST_HUNT;
          w_done  = 1'b0;
          w_ok    = 1'b0;
          w_len   = '0;
        end
      end

      default: w_state = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_dl       <= '0;
      r_dl_cnt   <= '0;
      r_asm      <= '0;
      r_asm_cnt  <= '0;
      r_cnt      <= '0;
      r_byte_out <= '0;
      r_byte_vld <= 1'b0;
      r_done     <= 1'b0;
      r_ok       <= 1'b0;
      r_len      <= '0;
      r_synced   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_dl       <= w_dl;
      r_dl_cnt   <= w_dl_cnt;
      r_asm      <= w_asm;
      r_asm_cnt  <= w_asm_cnt;
      r_cnt      <= w_cnt;
      r_byte_out <= w_byte_out;
      r_byte_vld <= w_byte_vld;
      r_done     <= w_done;
      r_ok       <= w_ok;
      r_len      <= w_len;
      r_synced   <= (w_state == ST_OPEN) || (w_state == ST_DATA);
    end
  end

  assign byte_out   = r_byte_out;
  assign byte_vld   = r_byte_vld;
  assign frame_done = r_done;
  assign frame_ok   = r_ok;
  assign frame_len  = r_len;
  assign synced     = r_synced;

endmodule

// File: tb/tb_hdlc_rx_ctrl.sv
// Scoreboard bench for hdlc_rx_ctrl: default instance plus a MAX_BYTES=2 instance for overflow.
module tb_hdlc_rx_ctrl;
  import hdlc_rx_pkg::*;

  typedef struct packed {
    logic       ok;
    logic [7:0] len;
  } rep_t;

  logic clk = 1'b0;
  logic rst, bit_in, ack, vld1, vld2;

  logic [7:0] byte_out1, byte_out2, frame_len1, frame_len2;
  logic byte_vld1, byte_vld2, frame_done1, frame_done2;
  logic frame_ok1, frame_ok2, synced1, synced2;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_byte1[$];
  logic [7:0] q_byte2[$];
  rep_t       q_rep1[$];
  rep_t       q_rep2[$];

  logic prev_done1 = 1'b0;
  logic prev_done2 = 1'b0;
  int   tx_ones    = 0;
  bit   sel        = 1'b0;
  bit   stall_en   = 1'b0;

  always #5 clk = ~clk;

  hdlc_rx_ctrl dut1 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(vld1), .ack(ack),
    .byte_out(byte_out1), .byte_vld(byte_vld1), .frame_done(frame_done1),
    .frame_ok(frame_ok1), .frame_len(frame_len1), .synced(synced1)
  );

  hdlc_rx_ctrl #(.MAX_BYTES(2), .LEN_W(8)) dut2 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(vld2), .ack(ack),
    .byte_out(byte_out2), .byte_vld(byte_vld2), .frame_done(frame_done2),
    .frame_ok(frame_ok2), .frame_len(frame_len2), .synced(synced2)
  );

  // One clock; outputs sampled 1 time unit after the edge and scored against the queues.
  task automatic tick();
    logic [7:0] eb;
    rep_t       er;
    @(posedge clk);
    #1;
    if (byte_vld1 === 1'b1) begin
      checks++;
      if (q_byte1.size() == 0) begin
        errors++;
        $display("FAIL dut1_byte unexpected byte_vld got %h want none", byte_out1);
      end else begin
        eb = q_byte1.pop_front();
        if (byte_out1 !== eb) begin
          errors++;
          $display("FAIL dut1_byte got %h want %h", byte_out1, eb);
        end
      end
    end
    if (byte_vld2 === 1'b1) begin
      checks++;
      if (q_byte2.size() == 0) begin
        errors++;
        $display("FAIL dut2_byte unexpected byte_vld got %h want none", byte_out2);
      end else begin
        eb = q_byte2.pop_front();
        if (byte_out2 !== eb) begin
          errors++;
          $display("FAIL dut2_byte got %h want %h", byte_out2, eb);
        end
      end
    end
    if (frame_done1 === 1'b1 && prev_done1 !== 1'b1) begin
      checks++;
      if (q_rep1.size() == 0) begin
        errors++;
        $display("FAIL dut1_report unexpected frame_done ok=%b len=%0d", frame_ok1, frame_len1);
      end else begin
        er = q_rep1.pop_front();
        if ({frame_ok1, frame_len1} !== er) begin
          errors++;
          $display("FAIL dut1_report got ok=%b len=%0d want ok=%b len=%0d",
                   frame_ok1, frame_len1, er.ok, er.len);
        end
      end
    end
    if (frame_done2 === 1'b1 && prev_done2 !== 1'b1) begin
      checks++;
      if (q_rep2.size() == 0) begin
        errors++;
        $display("FAIL dut2_report unexpected frame_done ok=%b len=%0d", frame_ok2, frame_len2);
      end else begin
        er = q_rep2.pop_front();
        if ({frame_ok2, frame_len2} !== er) begin
          errors++;
          $display("FAIL dut2_report got ok=%b len=%0d want ok=%b len=%0d",
                   frame_ok2, frame_len2, er.ok, er.len);
        end
      end
    end
    prev_done1 = frame_done1;
    prev_done2 = frame_done2;
  endtask

  task automatic drive_bit(input logic b);
    int n;
    n = stall_en ? int'($urandom_range(0, 2)) : 0;
    repeat (n) tick();
    bit_in = b;
    if (sel) vld2 = 1'b1;
    else     vld1 = 1'b1;
    tick();
    vld1 = 1'b0;
    vld2 = 1'b0;
  endtask

  task automatic send_raw(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) drive_bit(bits[i]);
  endtask

  task automatic send_flag();
    send_raw(16'(FLAG), 8);
    tx_ones = 0;
  endtask

  // Transmit-side zero stuffing: a 0 follows every run of five data 1s.
  task automatic send_data_bit(input logic b);
    drive_bit(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        drive_bit(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_out);
    if (expect_out) begin
      if (sel) q_byte2.push_back(b);
      else     q_byte1.push_back(b);
    end
    for (int i = 0; i < 8; i++) send_data_bit(b[i]);
  endtask

  task automatic expect_report(input logic ok, input logic [7:0] len);
    rep_t r;
    r.ok  = ok;
    r.len = len;
    if (sel) q_rep2.push_back(r);
    else     q_rep1.push_back(r);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bit_in = 1'b0; ack = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({byte_out1, byte_vld1, frame_done1, frame_ok1, frame_len1, synced1} !== 20'h0) begin
      errors++;
      $display("FAIL reset_dut1 got out=%h vld=%b done=%b ok=%b len=%0d sync=%b want all 0",
               byte_out1, byte_vld1, frame_done1, frame_ok1, frame_len1, synced1);
    end
    checks++;
    if ({byte_out2, byte_vld2, frame_done2, frame_ok2, frame_len2, synced2} !== 20'h0) begin
      errors++;
      $display("FAIL reset_dut2 got out=%h vld=%b done=%b ok=%b len=%0d sync=%b want all 0",
               byte_out2, byte_vld2, frame_done2, frame_ok2, frame_len2, synced2);
    end
  endtask

  task automatic test_good_frame();
    sel = 1'b0;
    send_flag();
    checks++;
    if (synced1 !== 1'b1) begin errors++; $display("FAIL good_synced got %b want 1", synced1); end
    expect_report(1'b1, 8'd1);
    send_byte(8'hA5, 1'b1);
    send_flag();
    checks++;
    if ({frame_done1, frame_ok1, frame_len1} !== {1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL good_report got done=%b ok=%b len=%0d want 1 1 1", frame_done1, frame_ok1, frame_len1);
    end
    do_ack();
    checks++;
    if ({frame_done1, frame_ok1, frame_len1} !== 10'h0) begin
      errors++;
      $display("FAIL good_ack got done=%b ok=%b len=%0d want 0 0 0", frame_done1, frame_ok1, frame_len1);
    end
  endtask

  task automatic test_stuffing();
    sel = 1'b0;
    send_flag();
    q_byte1.push_back(8'hFF);
    expect_report(1'b1, 8'd1);
    send_raw(16'h01DF, 9);
    send_flag();
    checks++;
    if ({frame_done1, frame_ok1, frame_len1} !== {1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL stuff_report got done=%b ok=%b len=%0d want 1 1 1", frame_done1, frame_ok1, frame_len1);
    end
    do_ack();
  endtask

  task automatic test_abort();
    sel = 1'b0;
    send_flag();
    send_byte(8'h12, 1'b1);
    send_byte(8'h00, 1'b0);
    expect_report(1'b0, 8'd1);
    send_raw(16'h003F, 6);
    ack = 1'b1;
    drive_bit(1'b1);
    ack = 1'b0;
    checks++;
    if ({frame_done1, frame_ok1, frame_len1} !== {1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL abort_report got done=%b ok=%b len=%0d want 1 0 1", frame_done1, frame_ok1, frame_len1);
    end
    tick();
    checks++;
    if (frame_done1 !== 1'b1) begin
      errors++;
      $display("FAIL abort_entry_ack got done=%b want 1", frame_done1);
    end
    send_raw(16'($urandom), 16);
    checks++;
    if ({frame_done1, frame_ok1, frame_len1} !== {1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL abort_hold got done=%b ok=%b len=%0d want 1 0 1", frame_done1, frame_ok1, frame_len1);
    end
    do_ack();
    checks++;
    if ({frame_done1, frame_ok1, frame_len1, synced1} !== 11'h0) begin
      errors++;
      $display("FAIL abort_ack got done=%b ok=%b len=%0d sync=%b want 0", frame_done1, frame_ok1, frame_len1, synced1);
    end
    send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b0);
    checks++;
    if (synced1 !== 1'b0) begin errors++; $display("FAIL abort_hunt got sync=%b want 0", synced1); end
  endtask

  task automatic test_misaligned();
    sel = 1'b0;
    send_flag();
    send_byte(8'h34, 1'b1);
    for (int i = 0; i < 4; i++) send_data_bit(1'b1);
    expect_report(1'b0, 8'd1);
    send_flag();
    checks++;
    if ({frame_done1, frame_ok1, frame_len1} !== {1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL misalign_report got done=%b ok=%b len=%0d want 1 0 1", frame_done1, frame_ok1, frame_len1);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    send_flag();
    send_flag();
    send_raw(16'h003F, 7);
    checks++;
    if ({synced1, frame_done1} !== 2'b10) begin
      errors++;
      $display("FAIL idle_flags got sync=%b done=%b want 1 0", synced1, frame_done1);
    end
    do_ack();
    checks++;
    if ({synced1, frame_done1} !== 2'b10) begin
      errors++;
      $display("FAIL idle_ack got sync=%b done=%b want 1 0", synced1, frame_done1);
    end
    stall_en = 1'b1;
    expect_report(1'b1, 8'd2);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_flag();
    stall_en = 1'b0;
    checks++;
    if ({frame_done1, frame_ok1, frame_len1} !== {1'b1, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL stall_report got done=%b ok=%b len=%0d want 1 1 2", frame_done1, frame_ok1, frame_len1);
    end
    do_ack();
  endtask

  task automatic test_overflow();
    sel = 1'b1;
    send_flag();
    send_byte(8'h55, 1'b1);
    send_byte(8'h33, 1'b1);
    expect_report(1'b0, 8'd2);
    send_byte(8'h0F, 1'b0);
    send_flag();
    checks++;
    if ({frame_done2, frame_ok2, frame_len2} !== {1'b1, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL overflow_report got done=%b ok=%b len=%0d want 1 0 2", frame_done2, frame_ok2, frame_len2);
    end
    do_ack();
    checks++;
    if ({frame_done2, frame_ok2, frame_len2} !== 10'h0) begin
      errors++;
      $display("FAIL overflow_ack got done=%b ok=%b len=%0d want 0 0 0", frame_done2, frame_ok2, frame_len2);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    send_flag();
    expect_report(1'b1, 8'd1);
    send_byte(8'hA5, 1'b1);
    send_flag();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({byte_out1, byte_vld1, frame_done1, frame_ok1, frame_len1, synced1} !== 20'h0) begin
      errors++;
      $display("FAIL rst_report got out=%h vld=%b done=%b ok=%b len=%0d sync=%b want all 0",
               byte_out1, byte_vld1, frame_done1, frame_ok1, frame_len1, synced1);
    end
    send_flag();
    send_byte(8'hA5, 1'b0);
    send_raw(16'h0000, 5);
    rst = 1'b1;
    drive_bit(1'b0);
    rst = 1'b0;
    checks++;
    if ({byte_out1, byte_vld1, frame_done1, frame_ok1, frame_len1, synced1} !== 20'h0) begin
      errors++;
      $display("FAIL rst_midbyte got out=%h vld=%b done=%b ok=%b len=%0d sync=%b want all 0",
               byte_out1, byte_vld1, frame_done1, frame_ok1, frame_len1, synced1);
    end
    send_byte(8'hA5, 1'b0);
    send_byte(8'hA5, 1'b0);
    checks++;
    if (synced1 !== 1'b0) begin errors++; $display("FAIL rst_hunt got sync=%b want 0", synced1); end
  endtask

  task automatic test_drain();
    repeat (4) tick();
    checks++;
    if (q_byte1.size() + q_byte2.size() + q_rep1.size() + q_rep2.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d bytes %0d reports outstanding want 0 0",
               q_byte1.size() + q_byte2.size(), q_rep1.size() + q_rep2.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_stuffing();
    test_abort();
    test_misaligned();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
